// File: rtl/apb_mem_slave.sv
// APB memory slave: DEPTH words of DATA_W bits, byte-lane writes, a
// programmable number of wait states per transfer, and an error response
// for word indices beyond DEPTH. Every output comes straight from a flop.
module apb_mem_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int WAIT_W = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    input  logic [WAIT_W-1:0]     wait_cycles,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // True when the byte address selects a word that physically exists.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [63:0] ext;
        ext = 64'(a);
        return (ext >> LSB) < 64'(DEPTH);
    endfunction

    // Word index; the sub-word byte offset is simply dropped.
    function automatic logic [MIDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[LSB +: MIDX_W];
    endfunction

    logic [0:0]        state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;

    // Transfer attributes captured in the setup cycle; the bus may change
    // freely afterwards without affecting the transfer in flight.
    logic [ADDR_W-1:0] addr_p0;
    logic              write_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [NBYTES-1:0] strb_p0;
    logic [WAIT_W-1:0] wait_p0;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic              hold;
    logic [WAIT_W-1:0] cnt_nxt;
    logic              rsp_fire;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_write;
    logic              rsp_ok;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_we;

    // Decode setup/continuation and prepare the response registered for the
    // pready cycle. With zero wait states that cycle directly follows setup,
    // so the response then uses the live bus instead of the captured copy.
    always_comb begin
        setup     = (state_q == ST_IDLE) && psel && !penable;
        hold      = psel && penable;
        cnt_nxt   = cnt_q + WAIT_W'(1);
        rsp_fire  = 1'b0;
        if (setup && (wait_cycles == '0)) begin
            rsp_fire = 1'b1;
        end else if ((state_q == ST_ACCESS) && !pready_q && hold && (cnt_nxt == wait_p0)) begin
            rsp_fire = 1'b1;
        end
        rsp_addr  = setup ? paddr  : addr_p0;
        rsp_write = setup ? pwrite : write_p0;
        rsp_ok    = in_range(rsp_addr);
        rsp_rdata = '0;
        if (!rsp_write && rsp_ok) begin
            rsp_rdata = mem[word_idx(rsp_addr)];
        end
        mem_we    = (state_q == ST_ACCESS) && pready_q && write_p0 && !pslverr_q;
    end

    // Control: state, wait counter and the registered response outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= rsp_fire;
            pslverr_q <= rsp_fire && !rsp_ok;
            prdata_q  <= rsp_fire ? rsp_rdata : '0;
            case (state_q)
                ST_IDLE: begin
                    if (setup) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (pready_q) begin
                        state_q <= ST_IDLE;
                    end else if (!hold) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
            endcase
        end
    end

    // Capture the transfer attributes at the closing edge of the setup cycle.
    always_ff @(posedge pclk) begin
        if (setup) begin
            addr_p0  <= paddr;
            write_p0 <= pwrite;
            wdata_p0 <= pwdata;
            strb_p0  <= pstrb;
            wait_p0  <= wait_cycles;
        end
    end

    // Commit enabled byte lanes at the edge that closes the pready cycle.
    always_ff @(posedge pclk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (strb_p0[i]) begin
                    mem[word_idx(addr_p0)][8*i +: 8] <= wdata_p0[8*i +: 8];
                end
            end
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule
